// File: rtl/ds_noise_shaper_mc_if.sv
// Control/sample bus of the multichannel noise shaper; the master drives
// enable, order and sample writes, the slave returns the quantised outputs.
interface ds_noise_shaper_mc_if #(
    parameter int CHANNELS  = 2,
    parameter int MAX_ORDER = 3,
    parameter int IN_BITS   = 16,
    parameter int OUT_BITS  = 1
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ORD_W = $clog2(MAX_ORDER + 1);

    // No back-pressure: a write with wr_en high is taken at that clock edge,
    // and q_out/frame_start are plain registered outputs.
    logic                         enable;
    logic [ORD_W-1:0]             order;
    logic                         wr_en;
    logic [CH_W-1:0]              wr_ch;
    logic [IN_BITS-1:0]           wr_data;
    logic [CHANNELS*OUT_BITS-1:0] q_out;
    logic                         frame_start;

    modport master (
        output enable, order, wr_en, wr_ch, wr_data,
        input  q_out, frame_start
    );

    modport slave (
        input  enable, order, wr_en, wr_ch, wr_data,
        output q_out, frame_start
    );
endinterface

// File: rtl/ds_noise_shaper_mc.sv
// Time-multiplexed error-feedback delta-sigma modulator, NTF = (1-z^-1)^M,
// one channel per enabled cycle in round-robin order.
module ds_noise_shaper_mc #(
    parameter int CHANNELS  = 2,
    parameter int MAX_ORDER = 3,
    parameter int IN_BITS   = 16,
    parameter int OUT_BITS  = 1,
    parameter int SREG_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    ds_noise_shaper_mc_if.slave bus
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ORD_W  = $clog2(MAX_ORDER + 1);
    localparam int W_BITS = ((IN_BITS > SREG_BITS) ? IN_BITS : SREG_BITS) + MAX_ORDER + 2;
    localparam int SHIFT  = IN_BITS - OUT_BITS + 1;

    localparam logic [CH_W-1:0]          LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic signed [W_BITS-1:0] QMAX_S  = W_BITS'(2 ** OUT_BITS - 1);
    localparam logic signed [W_BITS-1:0] SMAX    = (W_BITS'(1) <<< (SREG_BITS - 1)) - W_BITS'(1);
    localparam logic signed [W_BITS-1:0] SMIN    = ~SMAX;

    logic [IN_BITS-1:0]           r_x   [CHANNELS];
    logic signed [SREG_BITS-1:0]  r_res [CHANNELS][1:MAX_ORDER];
    logic [CHANNELS*OUT_BITS-1:0] r_q_out;
    logic [CH_W-1:0]              r_ch_idx;
    logic [ORD_W-1:0]             r_order_q;
    logic                         r_frame_start;

    logic                         w_wr_ok;
    logic                         w_wrap;
    logic [ORD_W-1:0]             w_order_lim;
    logic signed [W_BITS-1:0]     w_diff [0:MAX_ORDER][0:MAX_ORDER];
    logic signed [W_BITS-1:0]     w_f;
    logic signed [W_BITS-1:0]     w_w;
    logic signed [W_BITS-1:0]     w_qraw;
    logic signed [W_BITS-1:0]     w_res_full;
    logic [OUT_BITS-1:0]          w_q;
    logic signed [SREG_BITS-1:0]  w_res;

    generate
        if (CHANNELS == 2 ** CH_W) begin : g_wr_full
            assign w_wr_ok = bus.wr_en;
        end else begin : g_wr_range
            assign w_wr_ok = bus.wr_en && (bus.wr_ch < CH_W'(CHANNELS));
        end
        if (MAX_ORDER == 2 ** ORD_W - 1) begin : g_ord_full
            assign w_order_lim = bus.order;
        end else begin : g_ord_clamp
            assign w_order_lim = (bus.order > ORD_W'(MAX_ORDER)) ? ORD_W'(MAX_ORDER) : bus.order;
        end
    endgenerate

    assign w_wrap = bus.enable && (r_ch_idx == LAST_CH);

    // Forward-difference table over (0, r1, r2, ...): row m, column 0 equals
    // sum_k C(m,k)(-1)^k r_k, so the feedback term is its negation.
    always_comb begin
        for (int m = 0; m <= MAX_ORDER; m++) begin
            for (int j = 0; j <= MAX_ORDER; j++) begin
                w_diff[m][j] = '0;
            end
        end
        for (int j = 1; j <= MAX_ORDER; j++) begin
            w_diff[0][j] = W_BITS'(r_res[r_ch_idx][j]);
        end
        for (int m = 1; m <= MAX_ORDER; m++) begin
            for (int j = 0; j <= MAX_ORDER - m; j++) begin
                w_diff[m][j] = w_diff[m-1][j] - w_diff[m-1][j+1];
            end
        end
    end

    always_comb begin
        w_f    = -w_diff[r_order_q][0];
        w_w    = $signed({{(W_BITS - IN_BITS){1'b0}}, r_x[r_ch_idx]}) + w_f;
        w_qraw = w_w >>> SHIFT;
        if (w_w[W_BITS-1]) begin
            w_q = '0;
        end else if (w_qraw > QMAX_S) begin
            w_q = OUT_BITS'(2 ** OUT_BITS - 1);
        end else begin
            w_q = w_qraw[OUT_BITS-1:0];
        end
        w_res_full = w_w - ($signed({{(W_BITS - OUT_BITS){1'b0}}, w_q}) <<< SHIFT);
        if (w_res_full > SMAX) begin
            w_res = SREG_BITS'(SMAX);
        end else if (w_res_full < SMIN) begin
            w_res = SREG_BITS'(SMIN);
        end else begin
            w_res = SREG_BITS'(w_res_full);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_x[c] <= '0;
                for (int k = 1; k <= MAX_ORDER; k++) begin
                    r_res[c][k] <= '0;
                end
            end
            r_q_out       <= '0;
            r_ch_idx      <= '0;
            r_order_q     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_x[bus.wr_ch] <= bus.wr_data;
            end
            if (bus.enable) begin
                for (int k = MAX_ORDER; k >= 2; k--) begin
                    r_res[r_ch_idx][k] <= r_res[r_ch_idx][k-1];
                end
                r_res[r_ch_idx][1] <= w_res;
                r_q_out[int'(r_ch_idx) * OUT_BITS +: OUT_BITS] <= w_q;
                r_frame_start <= w_wrap;
                r_ch_idx      <= w_wrap ? '0 : r_ch_idx + 1'b1;
                // A new order starts the next frame on clean history; this
                // clear overrides the residue just written above.
                if (w_wrap) begin
                    r_order_q <= w_order_lim;
                    if (w_order_lim != r_order_q) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            for (int k = 1; k <= MAX_ORDER; k++) begin
                                r_res[c][k] <= '0;
                            end
                        end
                    end
                end
            end else begin
                r_frame_start <= 1'b0;
            end
        end
    end

    assign bus.q_out       = r_q_out;
    assign bus.frame_start = r_frame_start;
endmodule
